// File: rtl/response_misr_checker.sv
// response_misr_checker: folds y samples into a 32-bit MISR and checks it against a golden signature
// Ports: clk, rst_n (async active-low); start begins a run; y_valid qualifies y; golden is the
// expected signature; busy/done/pass report run status; signature and sample_cnt expose state.
module response_misr_checker #(
    parameter int          Y_W       = 258,
    parameter int          N_SAMPLES = 20,
    parameter logic [31:0] POLY      = 32'h04C11DB7,
    parameter logic [31:0] SEED      = 32'hFFFFFFFF
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           y_valid,
    input  logic [Y_W-1:0] y,
    input  logic [31:0]    golden,
    output logic           busy,
    output logic           done,
    output logic           pass,
    output logic [31:0]    signature,
    output logic [15:0]    sample_cnt
);
    localparam int NCH = (Y_W + 31) / 32;
    typedef enum logic [1:0] {IDLE, COLLECT, COMPARE, DONE} state_t;
    state_t state, state_nxt;
    logic [NCH*32-1:0] y_ext;
    logic [31:0] fold, sig_step, sig_nxt;
    logic [15:0] cnt_nxt;
    logic pass_nxt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            signature  <= 32'h0;
            sample_cnt <= 16'h0;
            pass       <= 1'b0;
        end else begin
            state      <= state_nxt;
            signature  <= sig_nxt;
            sample_cnt <= cnt_nxt;
            pass       <= pass_nxt;
        end
    end
    always_comb begin
        y_ext = '0;
        y_ext[Y_W-1:0] = y;
        fold = 32'h0;
        for (int i = 0; i < NCH; i++) fold = fold ^ y_ext[32*i +: 32];
        sig_step  = {signature[30:0], 1'b0} ^ (signature[31] ? POLY : 32'h0) ^ fold;
        state_nxt = state;
        sig_nxt   = signature;
        cnt_nxt   = sample_cnt;
        pass_nxt  = pass;
        case (state)
            IDLE, DONE: if (start) begin
                state_nxt = COLLECT;
                sig_nxt   = SEED;
                cnt_nxt   = 16'h0;
                pass_nxt  = 1'b0;
            end
            COLLECT: if (y_valid) begin
                sig_nxt = sig_step;
                cnt_nxt = sample_cnt + 16'd1;
                state_nxt = (cnt_nxt == 16'(N_SAMPLES)) ? COMPARE : COLLECT;
            end
            COMPARE: begin
                pass_nxt  = (signature == golden);
                state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end
    assign busy = (state == COLLECT) || (state == COMPARE);
    assign done = (state == DONE);
endmodule
